leitor_mem_coor: RTL and testbench

Sequential reader/unpacker for the object-coordinate memory. On a start pulse it walks every memory entry in address order, reads each packed word `{coor_x, coor_y, opcode}` and presents the unpacked fields to the update datapath through a valid/ready handshake. It sits between the coordinate memory read port and the movement/collision logic. It is the read-side counterpart of the coordinate write-back selector.

---
 rtl/leitor_mem_coor.sv | 126 ++++++++++++
 tb/tb_leitor_mem_coor.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leitor_mem_coor.sv
// Sequential reader/unpacker for the object-coordinate memory: scans every entry in address
// order and hands the unpacked {coor_x, coor_y, opcode} fields out over valido/pronto.
module leitor_mem_coor #(
   parameter int unsigned N      = 4,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned ADDR_W = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              iniciar,
   input  logic              pular_vazios,
   output logic [ADDR_W-1:0] mem_endereco,
   output logic              mem_leitura,
   input  logic [2*N+1:0]    mem_dado,
   output logic [N-1:0]      coor_x,
   output logic [N-1:0]      coor_y,
   output logic [1:0]        opcode,
   output logic [ADDR_W-1:0] indice,
   output logic              valido,
   input  logic              pronto,
   output logic              ocupado,
   output logic              fim
);

   typedef enum logic [2:0] {StOcioso, StLe, StEspera, StEntrega, StFim} state_e;

   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] end_q, end_d;
   logic              skip_q, skip_d;
   logic [N-1:0]      x_q, x_d;
   logic [N-1:0]      y_q, y_d;
   logic [1:0]        op_q, op_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              is_last;
   logic              empty_slot;

   assign is_last    = (cnt_q == LastAddr);
   assign empty_slot = skip_q && (mem_dado[1:0] == 2'b00);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      end_d   = end_q;
      skip_d  = skip_q;
      x_d     = x_q;
      y_d     = y_q;
      op_d    = op_q;
      idx_d   = idx_q;
      case (state_q)
         StOcioso: begin
            cnt_d = '0;
            if (iniciar) begin
               state_d = StLe;
               skip_d  = pular_vazios;
               end_d   = '0;
            end
         end
         StLe: state_d = StEspera;
         StEspera: begin
            x_d   = mem_dado[2*N+1:N+2];
            y_d   = mem_dado[N+1:2];
            op_d  = mem_dado[1:0];
            idx_d = cnt_q;
            if (!empty_slot) begin
               state_d = StEntrega;
            end else if (is_last) begin
               state_d = StFim;
            end else begin
               state_d = StLe;
               cnt_d   = cnt_q + ADDR_W'(1);
               end_d   = cnt_q + ADDR_W'(1);
            end
         end
         StEntrega: begin
            if (pronto) begin
               if (is_last) begin
                  state_d = StFim;
               end else begin
                  state_d = StLe;
                  cnt_d   = cnt_q + ADDR_W'(1);
                  end_d   = cnt_q + ADDR_W'(1);
               end
            end
         end
         StFim: state_d = StOcioso;
         default: state_d = StOcioso;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= StOcioso;
         cnt_q   <= '0;
         end_q   <= '0;
         skip_q  <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         op_q    <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         end_q   <= end_d;
         skip_q  <= skip_d;
         x_q     <= x_d;
         y_q     <= y_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
      end
   end

   // Control outputs decode straight from the state so reset clears them asynchronously.
   assign mem_endereco = end_q;
   assign mem_leitura  = (state_q == StLe);
   assign valido       = (state_q == StEntrega);
   assign ocupado      = (state_q != StOcioso);
   assign fim          = (state_q == StFim);
   assign coor_x       = x_q;
   assign coor_y       = y_q;
   assign opcode       = op_q;
   assign indice       = idx_q;

endmodule

// File: tb/tb_leitor_mem_coor.sv
// Randomized bench for leitor_mem_coor: an event-level scan model checks every cycle,
// directed scenarios pin the model with literal expectations.
module tb_leitor_mem_coor;
   localparam int N      = 4;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;
   localparam int DW     = 2 * N + 2;

   logic              clock = 1'b0;
   logic              reset;
   logic              iniciar;
   logic              pular_vazios;
   logic [ADDR_W-1:0] mem_endereco;
   logic              mem_leitura;
   logic [DW-1:0]     mem_dado;
   logic [N-1:0]      coor_x;
   logic [N-1:0]      coor_y;
   logic [1:0]        opcode;
   logic [ADDR_W-1:0] indice;
   logic              valido;
   logic              pronto;
   logic              ocupado;
   logic              fim;

   leitor_mem_coor #(.N(N), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .pular_vazios(pular_vazios),
      .mem_endereco(mem_endereco), .mem_leitura(mem_leitura), .mem_dado(mem_dado),
      .coor_x(coor_x), .coor_y(coor_y), .opcode(opcode), .indice(indice),
      .valido(valido), .pronto(pronto), .ocupado(ocupado), .fim(fim)
   );

   always #5 clock = ~clock;

   logic [DW-1:0] mem [DEPTH];
   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always @(posedge clock) cyc <= cyc + 1;

   // Memory with one-cycle read latency; garbage when not reading.
   always @(posedge clock) begin
      if (mem_leitura) mem_dado <= mem[mem_endereco];
      else             mem_dado <= DW'($urandom);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scan model: tracks when the next read, presentation or completion must appear.
   bit            m_idle = 1'b1;
   bit            m_skip;
   bit            pres_on;
   bit            idle_next;
   int            next_addr;
   int            last_addr = 0;
   int            exp_read_at = -1;
   int            exp_fim_at = -1;
   int            pres_at;
   int            pres_idx;
   logic [DW-1:0] pres_data;
   logic [DW-1:0] d;
   bit            exp_v;
   int            seen_idx[$];
   int            fim_count = 0;

   always @(negedge clock) begin
      if (!reset) begin
         chk("rst_leitura", mem_leitura, 0);
         chk("rst_valido", valido, 0);
         chk("rst_ocupado", ocupado, 0);
         chk("rst_fim", fim, 0);
         chk("rst_endereco", mem_endereco, 0);
         chk("rst_fields", {coor_x, coor_y, opcode, indice}, 0);
         m_idle      = 1'b1;
         pres_on     = 1'b0;
         exp_read_at = -1;
         exp_fim_at  = -1;
         last_addr   = 0;
      end else begin
         idle_next = m_idle;
         chk("ocupado", ocupado, !m_idle);
         chk("mem_leitura", mem_leitura, cyc == exp_read_at);
         if (cyc == exp_read_at) begin
            chk("mem_endereco", mem_endereco, next_addr);
            last_addr = next_addr;
            d = mem[next_addr];
            if (m_skip && d[1:0] == 2'b00) begin
               if (next_addr == DEPTH - 1) exp_fim_at = cyc + 2;
               else exp_read_at = cyc + 2;
            end else begin
               pres_on   = 1'b1;
               pres_at   = cyc + 2;
               pres_data = d;
               pres_idx  = next_addr;
            end
            next_addr++;
         end else begin
            chk("endereco_hold", mem_endereco, last_addr);
         end
         exp_v = pres_on && cyc >= pres_at;
         chk("valido", valido, exp_v);
         if (valido && exp_v) begin
            chk("coor_x", coor_x, pres_data[2*N+1:N+2]);
            chk("coor_y", coor_y, pres_data[N+1:2]);
            chk("opcode", opcode, pres_data[1:0]);
            chk("indice", indice, pres_idx);
            if (pronto) begin
               pres_on = 1'b0;
               seen_idx.push_back(pres_idx);
               if (next_addr == DEPTH) exp_fim_at = cyc + 1;
               else exp_read_at = cyc + 1;
            end
         end
         chk("fim", fim, cyc == exp_fim_at);
         if (cyc == exp_fim_at) begin
            idle_next = 1'b1;
            fim_count++;
         end
         if (m_idle && iniciar) begin
            idle_next   = 1'b0;
            m_skip      = pular_vazios;
            next_addr   = 0;
            exp_read_at = cyc + 1;
            seen_idx.delete();
         end
         m_idle = idle_next;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic start(input bit skip);
      pular_vazios = skip;
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      pular_vazios = ~skip;  // must have been latched already
   endtask

   task automatic wait_fim(input int lim, output int n);
      n = 0;
      while (!fim && n < lim) begin
         tick();
         n++;
      end
      chk("fim_seen", fim, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int n;
   int fc;
   int exp_skip[5] = '{0, 3, 4, 5, 6};

   initial begin
      reset = 1'b0;
      iniciar = 1'b0;
      pular_vazios = 1'b0;
      pronto = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      chk("post_rst_outputs", {mem_endereco, mem_leitura, valido, ocupado, fim}, 0);
      chk("post_rst_fields", {coor_x, coor_y, opcode, indice}, 0);

      // Single-entry unpack
      mem[0] = 10'b0011_0101_01;
      pronto = 1'b1;
      start(1'b0);
      tick();
      tick();
      chk("single_valido", valido, 1);
      chk("single_x", coor_x, 3);
      chk("single_y", coor_y, 5);
      chk("single_op", opcode, 2'b01);
      chk("single_idx", indice, 0);
      wait_fim(40, n);
      tick();

      // Full scan with pronto high
      for (int i = 0; i < DEPTH; i++) mem[i] = {4'(i), 4'(15 - i), 2'b10};
      fc = fim_count;
      start(1'b0);
      wait_fim(40, n);
      chk("full_latency", n + 1, 25);
      chk("full_count", seen_idx.size(), 8);
      repeat (4) tick();
      chk("full_fim_once", fim_count - fc, 1);

      // Backpressure on entry 2
      start(1'b0);
      n = 0;
      while (!(valido && indice == 2) && n < 20) begin
         tick();
         n++;
      end
      pronto = 1'b0;
      repeat (5) begin
         tick();
         chk("bp_valido", valido, 1);
         chk("bp_fields", {coor_x, coor_y, opcode, indice}, {4'd2, 4'd13, 2'b10, 3'd2});
         chk("bp_leitura", mem_leitura, 0);
         chk("bp_endereco", mem_endereco, 2);
      end
      pronto = 1'b1;
      wait_fim(40, n);
      tick();

      // Skip empty slots, then the same memory without skipping
      for (int i = 0; i < DEPTH; i++)
         mem[i] = {4'(i), 4'(15 - i), (i == 1 || i == 2 || i == 7) ? 2'b00 : 2'b11};
      start(1'b1);
      wait_fim(40, n);
      chk("skip_count", seen_idx.size(), 5);
      for (int i = 0; i < 5 && i < seen_idx.size(); i++) chk("skip_idx", seen_idx[i], exp_skip[i]);
      tick();
      start(1'b0);
      wait_fim(40, n);
      chk("noskip_count", seen_idx.size(), 8);

      // Ignored mid-scan start, then restart right after fim
      tick();
      start(1'b0);
      repeat (6) tick();
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      wait_fim(40, n);
      chk("ignored_count", seen_idx.size(), 8);
      tick();
      start(1'b0);
      chk("restart_leitura", mem_leitura, 1);
      chk("restart_addr", mem_endereco, 0);
      wait_fim(40, n);
      tick();

      // Asynchronous reset during ENTREGA
      start(1'b0);
      n = 0;
      while (!valido && n < 20) begin
         tick();
         n++;
      end
      fc = fim_count;
      reset = 1'b0;
      #1;
      chk("async_valido", valido, 0);
      chk("async_ocupado", ocupado, 0);
      repeat (2) tick();
      reset = 1'b1;
      repeat (4) tick();
      chk("async_no_fim", fim_count - fc, 0);
      start(1'b0);
      wait_fim(40, n);
      chk("after_rst_first", seen_idx.size() > 0 ? seen_idx[0] : -1, 0);
      tick();

      // Randomized scans
      for (int s = 0; s < 25; s++) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] = DW'($urandom);
            if ($urandom_range(2, 0) == 0) mem[i][1:0] = 2'b00;
         end
         pronto = $urandom_range(1, 0);
         start($urandom_range(1, 0));
         n = 0;
         while (!fim && n < 300) begin
            pronto  = ($urandom_range(3, 0) != 0);
            iniciar = ($urandom_range(15, 0) == 0);
            pular_vazios = $urandom_range(1, 0);
            tick();
            n++;
         end
         iniciar = 1'b0;
         chk("rand_fim", fim, 1);
         repeat ($urandom_range(3, 1)) tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
